// File: rtl/present_masked_pkg.sv
// rtl/present_masked_pkg.sv - shared constants, FSM encoding and pLayer index map
// for the masked nibble-serial PRESENT round sequencer.
package present_masked_pkg;

    localparam int STATE_W  = 64;
    localparam int NIBBLE_W = 4;
    localparam int NIBBLES  = 16;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        PERM
    } seq_state_e;

    // Destination bit of source bit i; bit 63 is the fixed point of the map.
    function automatic int player_idx(input int i);
        return (i == STATE_W - 1) ? (STATE_W - 1) : ((16 * i) % (STATE_W - 1));
    endfunction

endpackage

// File: rtl/present_player.sv
// rtl/present_player.sv - PRESENT pLayer bit permutation on one 64-bit share,
// purely combinational.
module present_player
    import present_masked_pkg::*;
(
    input  logic [STATE_W-1:0] i_data,
    output logic [STATE_W-1:0] o_data
);

    for (genvar i = 0; i < STATE_W; i++) begin : g_bit
        localparam int P = player_idx(i);
        assign o_data[P] = i_data[i];
    end

endmodule

// File: rtl/present_masked_nibble_round_seq.sv
// rtl/present_masked_nibble_round_seq.sv - two-share PRESENT round sequencer:
// key add, nibble-serial feed/collect through the masked S-box, then pLayer.
module present_masked_nibble_round_seq
    import present_masked_pkg::*;
#(
    parameter int SBOX_LATENCY = 2,
    parameter int NIBBLES      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [STATE_W-1:0]  pt0,
    input  logic [STATE_W-1:0]  pt1,
    input  logic                start,
    input  logic [STATE_W-1:0]  rk0,
    input  logic [STATE_W-1:0]  rk1,
    output logic                sbox_valid,
    output logic [NIBBLE_W-1:0] sbox_in0,
    output logic [NIBBLE_W-1:0] sbox_in1,
    input  logic [NIBBLE_W-1:0] sbox_out0,
    input  logic [NIBBLE_W-1:0] sbox_out1,
    output logic                busy,
    output logic                done,
    output logic [STATE_W-1:0]  state0,
    output logic [STATE_W-1:0]  state1
);

    localparam logic [3:0] LAST = 4'(NIBBLES - 1);

    seq_state_e               r_state;
    seq_state_e               w_next;
    logic [3:0]               r_rd_idx;
    logic [3:0]               r_wr_idx;
    logic [SBOX_LATENCY-1:0]  r_vdly;
    logic [SBOX_LATENCY:0]    w_vchain;
    logic                     w_wb;
    logic                     r_done;
    logic [STATE_W-1:0]       r_state0;
    logic [STATE_W-1:0]       r_state1;
    logic [STATE_W-1:0]       w_perm0;
    logic [STATE_W-1:0]       w_perm1;

    present_player u_player0 (.i_data(r_state0), .o_data(w_perm0));
    present_player u_player1 (.i_data(r_state1), .o_data(w_perm1));

    assign w_vchain = {r_vdly, sbox_valid};
    assign w_wb     = r_vdly[SBOX_LATENCY-1];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start && !load) w_next = FEED;
            FEED:    if (r_rd_idx == LAST) w_next = DRAIN;
            DRAIN:   if (w_wb && (r_wr_idx == LAST)) w_next = PERM;
            PERM:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign sbox_valid = (r_state == FEED);
    assign sbox_in0   = sbox_valid ? r_state0[{r_rd_idx, 2'b00} +: NIBBLE_W] : '0;
    assign sbox_in1   = sbox_valid ? r_state1[{r_rd_idx, 2'b00} +: NIBBLE_W] : '0;
    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign state0     = r_state0;
    assign state1     = r_state1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rd_idx <= '0;
            r_wr_idx <= '0;
            r_vdly   <= '0;
            r_done   <= 1'b0;
            r_state0 <= '0;
            r_state1 <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == PERM);
            r_vdly  <= w_vchain[SBOX_LATENCY-1:0];
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_state0 <= pt0;
                        r_state1 <= pt1;
                    end else if (start) begin
                        r_state0 <= r_state0 ^ rk0;
                        r_state1 <= r_state1 ^ rk1;
                        r_rd_idx <= '0;
                        r_wr_idx <= '0;
                    end
                end
                FEED: begin
                    if (r_rd_idx != LAST) r_rd_idx <= r_rd_idx + 4'd1;
                end
                PERM: begin
                    r_state0 <= w_perm0;
                    r_state1 <= w_perm1;
                    r_rd_idx <= '0;
                    r_wr_idx <= '0;
                end
                default: ;
            endcase
            // Write-back trails the feed by the S-box latency, so it never hits the nibble being read.
            if (w_wb) begin
                r_state0[{r_wr_idx, 2'b00} +: NIBBLE_W] <= sbox_out0;
                r_state1[{r_wr_idx, 2'b00} +: NIBBLE_W] <= sbox_out1;
                if (r_wr_idx != LAST) r_wr_idx <= r_wr_idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_present_masked_nibble_round_seq.sv
// tb/tb_present_masked_nibble_round_seq.sv - directed bench driving three sequencers
// (S-box latency 1, 2, 4) in lockstep against a masked S-box model and golden round.
module tb_present_masked_nibble_round_seq;

    localparam int NG = 3;

    logic                   clk   = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   load  = 1'b0;
    logic                   start = 1'b0;
    logic [63:0]            pt0   = '0;
    logic [63:0]            pt1   = '0;
    logic [63:0]            rk0   = '0;
    logic [63:0]            rk1   = '0;
    logic [NG-1:0]          sv;
    logic [NG-1:0][3:0]     si0, si1, so0, so1;
    logic [NG-1:0]          busy, done;
    logic [NG-1:0][63:0]    st0, st1;

    int ecnt   = 0;
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    function automatic logic [3:0] sbox_f(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : 4;
    endfunction

    function automatic logic [63:0] ref_round(input logic [63:0] s, input logic [63:0] k);
        logic [63:0] x;
        logic [63:0] y;
        x = s ^ k;
        y = '0;
        for (int j = 0; j < 16; j++) x[4*j +: 4] = sbox_f(x[4*j +: 4]);
        for (int i = 0; i < 63; i++) y[(i * 16) % 63] = x[i];
        y[63] = x[63];
        return y;
    endfunction

    for (genvar g = 0; g < NG; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        logic [7:0] pipe [L];

        present_masked_nibble_round_seq #(.SBOX_LATENCY(L), .NIBBLES(16)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load),
            .pt0        (pt0),
            .pt1        (pt1),
            .start      (start),
            .rk0        (rk0),
            .rk1        (rk1),
            .sbox_valid (sv[g]),
            .sbox_in0   (si0[g]),
            .sbox_in1   (si1[g]),
            .sbox_out0  (so0[g]),
            .sbox_out1  (so1[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .state0     (st0[g]),
            .state1     (st1[g])
        );

        // Fresh mask per nibble: share1 = m, share0 = S(x) ^ m.
        always @(posedge clk) begin
            logic [3:0] m;
            m = 4'($urandom);
            pipe[0] <= sv[g] ? {sbox_f(si0[g] ^ si1[g]) ^ m, m} : 8'h00;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign so0[g] = pipe[L-1][7:4];
        assign so1[g] = pipe[L-1][3:0];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic run_round(input logic [63:0] p, input logic [63:0] m,
                             input logic [63:0] k0, input logic [63:0] k1, input bit poke);
        logic [63:0] exp;
        int dlat [NG];
        int vcnt [NG];
        int dcnt [NG];
        int t0;
        exp = ref_round(p, k0 ^ k1);
        pt0  = p ^ m;
        pt1  = m;
        load = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        rk0   = k0;
        rk1   = k1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0    = ecnt;
        for (int g = 0; g < NG; g++) begin
            dlat[g] = -1;
            vcnt[g] = 0;
            dcnt[g] = 0;
        end
        for (int i = 0; i < 60; i++) begin
            for (int g = 0; g < NG; g++) begin
                if (sv[g]) vcnt[g]++;
                if (done[g]) begin
                    dcnt[g]++;
                    if (dlat[g] < 0) dlat[g] = ecnt - t0 + 1;
                end
            end
            if (poke && i == 16) begin
                start = 1'b1;
                load  = 1'b1;
                rk0   = ~k0;
                pt0   = ~p;
            end
            if (poke && i == 17) begin
                start = 1'b0;
                load  = 1'b0;
                for (int g = 0; g < NG; g++) check_eq("busy_after_drain_start", 64'(busy[g]), 64'd1);
            end
            @(negedge clk);
        end
        for (int g = 0; g < NG; g++) begin
            check_eq("done_cycle", 64'(dlat[g]), 64'(18 + lat_of(g)));
            check_eq("valid_cycles", 64'(vcnt[g]), 64'd16);
            check_eq("done_pulses", 64'(dcnt[g]), 64'd1);
            check_eq("round_result", st0[g] ^ st1[g], exp);
            check_eq("idle_busy", 64'(busy[g]), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] a, b;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NG; g++) begin
            check_eq("reset_state", st0[g] | st1[g], 64'd0);
            check_eq("reset_ctl", 64'({busy[g], done[g], sv[g], si0[g], si1[g]}), 64'd0);
        end

        run_round(64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        for (int g = 0; g < NG; g++)
            check_eq("zero_vector", st0[g] ^ st1[g], 64'hFFFFFFFF00000000);

        for (int n = 0; n < 100; n++)
            run_round(64'h0123456789ABCDEF, {$urandom, $urandom},
                      {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);

        run_round({$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);

        a     = 64'hA5A5_0F0F_1234_5678;
        b     = 64'h5A5A_F0F0_8765_4321;
        pt0   = a;
        pt1   = b;
        load  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        for (int g = 0; g < NG; g++) begin
            check_eq("load_start_busy", 64'(busy[g]), 64'd0);
            check_eq("load_start_s0", st0[g], a);
            check_eq("load_start_s1", st1[g], b);
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < NG; g++) check_eq("load_start_busy_later", 64'(busy[g]), 64'd0);

        pt0  = {$urandom, $urandom};
        pt1  = {$urandom, $urandom};
        load = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        rk0   = {$urandom, $urandom};
        rk1   = {$urandom, $urandom};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < NG; g++) begin
            check_eq("midreset_state", st0[g] | st1[g], 64'd0);
            check_eq("midreset_ctl", 64'({busy[g], done[g], sv[g], si0[g], si1[g]}), 64'd0);
        end
        #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        for (int g = 0; g < NG; g++) begin
            check_eq("late_result_no_write", st0[g] | st1[g], 64'd0);
            check_eq("after_reset_busy", 64'(busy[g]), 64'd0);
        end
        run_round({$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/present_masked_nibble_round_seq.md
Name: present_masked_nibble_round_seq

Overview:
- Round sequencer for the 2-share nibble-serial PRESENT-80 encryption core.
- Holds both 64-bit state shares and adds the round-key shares.
- Streams nibbles, share by share, into the masked S-box pipeline (step1/step2 GHPC gadgets), collects the S-box results after a fixed latency, then applies pLayer to each share.
- Sits directly upstream and downstream of the S-box chain: it produces the S-box inputs and consumes the S-box outputs.

Parameters:
- SBOX_LATENCY, 2: cycles from sbox_valid high to the matching sbox_out nibble being valid. Must be ≥1.
- NIBBLES, 16: number of state nibbles per round. Fixed for PRESENT; not to be overridden.

Ports:
- clk  in  1  clock; all registers sample on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  in IDLE, capture pt0/pt1 into the state shares.
- pt0  in  64  plaintext share 0.
- pt1  in  64  plaintext share 1.
- start  in  1  in IDLE, begin one round.
- rk0  in  64  round-key share 0; sampled on the accepted start.
- rk1  in  64  round-key share 1; sampled on the accepted start.
- sbox_valid  out  1  high while a nibble is presented to the S-box.
- sbox_in0  out  4  share-0 nibble to the S-box.
- sbox_in1  out  4  share-1 nibble to the S-box.
- sbox_out0  in  4  share-0 S-box result.
- sbox_out1  in  4  share-1 S-box result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the round has completed.
- state0  out  64  current state, share 0.
- state1  out  64  current state, share 1.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - state0, state1, both counters and the valid delay line are cleared to 0.
  - Outputs: busy=0, done=0, sbox_valid=0, sbox_in0=sbox_in1=0.
  - Any in-flight S-box results are discarded.
- FSM states and transitions:
  - IDLE:
    - load=1 → state0←pt0, state1←pt1.
    - start=1 with load=0 → state0←state0^rk0, state1←state1^rk1; rd_idx=0, wr_idx=0; go to FEED.
    - load and start together → load wins, start is dropped.
  - FEED:
    - sbox_valid=1, sbox_in0=state0[4*rd_idx+:4], sbox_in1=state1[4*rd_idx+:4].
    - rd_idx increments every cycle.
    - After the rd_idx=15 cycle, go to DRAIN.
  - DRAIN:
    - sbox_valid=0; sbox_in0 and sbox_in1 are driven to 0.
    - Stay until the 16th write-back has completed, then go to PERM.
  - PERM (one cycle):
    - Each share is permuted separately: state_s[(16*i) mod 63] ← state_s[i] for i=0..62, and bit 63 stays at bit 63.
    - Next cycle: IDLE with done=1 for exactly one cycle.
- Write-back:
  - sbox_valid is delayed by SBOX_LATENCY in a shift register.
  - When the delayed valid is high: state0[4*wr_idx+:4]←sbox_out0, state1[4*wr_idx+:4]←sbox_out1, and wr_idx increments.
  - Write-back overlaps FEED; reads and writes never target the same nibble in the same cycle because rd_idx is always ahead of wr_idx.
- Timing:
  - Accepted start at edge t.
  - Nibble k is presented in cycle t+1+k.
  - Its result is captured at the end of cycle t+1+k+L.
  - PERM runs in cycle t+17+L.
  - done is high in cycle t+18+L; with L=2, done is high in cycle t+20.
- start or load while busy: ignored, no effect.
- Counters are 4 bits and wrap 15→0 only on round completion, never mid-round.
- Masking rule: share-0 and share-1 datapaths are never combined in any logic, mux select or enable. The key XOR and pLayer are strictly per share.
- state0/state1 are registered outputs and are stable outside FEED/DRAIN/PERM.

Decomposition:
- Shared package present_masked_pkg:
  - constants STATE_W=64, NIBBLE_W=4, NIBBLES=16;
  - FSM state enum {IDLE, FEED, DRAIN, PERM};
  - pLayer bit-index function.
- One natural sub-module: present_player, a purely combinational 64-bit permutation instantiated once per share.

Test Plan:
- Bench S-box model: fixed latency L; outputs share1=m (random) and share0=S(x0^x1)^m.
- Zero vector: pt0=pt1=0, rk0=rk1=0, start → done at cycle t+20 (L=2). Recombined state0^state1 = 0xFFFFFFFF00000000.
- Masked equivalence: pt0=0x0123456789ABCDEF^M, pt1=M (random M), rk split randomly over 100 rounds → recombined state matches an unmasked golden PRESENT round every time.
- Latency sweep: SBOX_LATENCY=1, 2, 4 → sbox_valid high for exactly 16 cycles; done at t+18+L; nibble k written to index k.
- Reset mid-round: assert rst_n=0 in FEED (rd_idx=7) → outputs and state are 0 immediately. A late S-box result after release causes no write. A new load/start then completes normally.
- Protocol corners: start during DRAIN → ignored and busy stays high. load+start in the same IDLE cycle → state equals pt and busy stays 0.
